sar_logic: RTL and testbench
============================

Name: sar_logic

Overview:
- Successive-approximation register controller for the low-resolution SAR ADC test chips.
- Consumes the comparator decision `comp` once per clock and drives the capacitive-DAC trial code MSB-first.
- Emits an N-bit conversion result with a one-cycle valid strobe.
- Sits between the analog comparator/DAC macro and the digital readout; the sar stimulus bench is the driver.

Parameters:
- N, 5, conversion resolution in bits (2..12).
- SAMPLE_CYCLES, 2, number of clocks the `sample` output is held high before conversion (1..15).
- CONTINUOUS, 0, when 1 a new conversion starts automatically after each result, with no `start` needed.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  conversion request, sampled in IDLE only
- comp  input  1  comparator output; 1 = Vin >= DAC(trial code), keep bit
- sample  output  1  track/hold switch control, high during SAMPLE
- dac_code  output  N  trial code to DAC
- result  output  N  last completed conversion, held until next completion
- valid  output  1  one-cycle strobe, result updated
- busy  output  1  high in SAMPLE and CONVERT

Behaviour:
- Reset values (applied at a clk edge with reset=1, overriding everything): state IDLE; sample=0, dac_code=0, result=0, valid=0, busy=0; bit index=N-1; sample counter=0.
- States: IDLE, SAMPLE, CONVERT. All outputs are registered.
- IDLE:
  - On an edge with start=1 (or CONTINUOUS=1): go to SAMPLE, sample<=1, busy<=1, counter<=SAMPLE_CYCLES-1, dac_code<=0.
  - start=0: remain in IDLE; dac_code holds its value.
- SAMPLE:
  - Each edge: if counter!=0, decrement.
  - Else go to CONVERT: sample<=0, dac_code<=1<<(N-1), bit index<=N-1.
- CONVERT, at each edge, with i = bit index:
  - dac_code[i]<=comp.
  - If i>0: dac_code[i-1]<=1, i<=i-1.
  - If i==0: result<={dac_code[N-1:1],comp}, valid<=1, dac_code<=same value, busy<=0, state<=IDLE. With CONTINUOUS=1, state<=SAMPLE instead: sample<=1, busy stays 1, counter reloaded.
- valid is high exactly one cycle per conversion; it is 0 in every other cycle.
- Latency: with the start edge as E0:
  - sample is high for edges E0+1..E0+SAMPLE_CYCLES.
  - Decisions occur at edges E0+SAMPLE_CYCLES+1 .. E0+SAMPLE_CYCLES+N.
  - valid is high in the cycle after edge E0+SAMPLE_CYCLES+N.
- Throughput:
  - CONTINUOUS=1: one result every SAMPLE_CYCLES+N clocks.
  - CONTINUOUS=0: the next start is accepted no earlier than the valid cycle.
- start while busy=1 is ignored and not queued. start held high in IDLE simply retriggers.
- comp is sampled only in CONVERT; it is don't-care elsewhere.
- Reset mid-conversion: abort immediately to the reset values. result is cleared to 0 and no valid is issued.
- Boundary codes:
  - comp=1 on every decision gives all-ones (2^N-1).
  - comp=0 on every decision gives 0.
- dac_code never exceeds N bits; there are no arithmetic carries.

Test Plan:
- Reset then idle: hold reset 2 cycles, start=0 for 20 cycles -> all outputs 0, sample never rises, valid never pulses.
- Model comparator with comp=(VIN>=dac_code), VIN=19, N=5, SAMPLE_CYCLES=2, single start pulse:
  - sample high exactly 2 cycles.
  - dac_code sequence 16,24,20,18,19.
  - result=19, valid single pulse at start+7 cycles, busy low afterwards.
- Extremes: VIN=0 -> dac_code 16,8,4,2,1, result=0. VIN=31 -> dac_code 16,24,28,30,31, result=31.
- Fixed stimulus: comp held 1 for the first two decisions, then 0 -> result=24 (11000b). Second start with comp=1 throughout -> result=31, previous result held until that valid.
- Start pulses during SAMPLE and CONVERT -> ignored, exactly one valid per accepted start. Reset asserted at the third decision -> outputs return to 0 next edge, no valid, and a later start converts normally.
- CONTINUOUS=1, VIN stepped 5 -> 27 between conversions -> results 5 then 27, valid every 7 cycles, busy constantly 1 after the first start.

Source files
------------

// File: rtl/sar_logic.sv
// Successive-approximation register controller: samples, then resolves an
// N-bit code MSB-first from the comparator decision and strobes the result.
module sar_logic #(
  parameter int N             = 5,
  parameter int SAMPLE_CYCLES = 2,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         comp,
  output logic         sample,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] result,
  output logic         valid,
  output logic         busy
);

  localparam int          IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
  localparam logic [3:0]  CNT_LOAD = 4'(SAMPLE_CYCLES - 1);
  localparam logic [N-1:0] MSB_ONE = N'(1) << (N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [3:0]    cnt, cnt_n;
  logic          sample_n, valid_n, busy_n;
  logic [N-1:0]  dac_n, result_n;

  // Next-state and next-output computation; every output is then registered.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    sample_n = sample;
    valid_n  = 1'b0;
    busy_n   = busy;
    dac_n    = dac_code;
    result_n = result;
    case (state)
      IDLE: begin
        if (start || CONTINUOUS) begin
          state_n  = SAMPLE;
          sample_n = 1'b1;
          busy_n   = 1'b1;
          cnt_n    = CNT_LOAD;
          dac_n    = '0;
        end else begin
          state_n = IDLE;
        end
      end
      SAMPLE: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n  = CONVERT;
          sample_n = 1'b0;
          dac_n    = MSB_ONE;
          idx_n    = IDX_TOP;
        end
      end
      CONVERT: begin
        // Keep or drop the bit under trial, then set the next lower trial bit.
        dac_n[idx] = comp;
        if (idx != '0) begin
          dac_n[idx - IW'(1)] = 1'b1;
          idx_n               = idx - IW'(1);
        end else begin
          result_n = {dac_code[N-1:1], comp};
          valid_n  = 1'b1;
          if (CONTINUOUS) begin
            state_n  = SAMPLE;
            sample_n = 1'b1;
            cnt_n    = CNT_LOAD;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        sample_n = 1'b0;
        busy_n   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= IDX_TOP;
      cnt      <= 4'd0;
      sample   <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      dac_code <= '0;
      result   <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      sample   <= sample_n;
      valid    <= valid_n;
      busy     <= busy_n;
      dac_code <= dac_n;
      result   <= result_n;
    end
  end

endmodule

// File: tb/tb_sar_logic.sv
// Scoreboard bench for sar_logic: one single-shot instance and one
// continuous-mode instance, both N=5, SAMPLE_CYCLES=2.
module tb_sar_logic;

  logic       clk = 1'b0;
  logic       reset, start, comp;
  logic       sample, valid, busy;
  logic [4:0] dac_code, result;

  logic       reset_c, start_c, comp_c;
  logic       sample_c, valid_c, busy_c;
  logic [4:0] dac_c, result_c;
  logic [4:0] vin_c;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int last_valid_c = -1;
  logic [4:0] q[$];
  logic [4:0] qc[$];
  logic [4:0] last_result = 5'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_logic #(.N(5), .SAMPLE_CYCLES(2), .CONTINUOUS(1'b0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .comp(comp),
    .sample(sample), .dac_code(dac_code), .result(result),
    .valid(valid), .busy(busy)
  );

  sar_logic #(.N(5), .SAMPLE_CYCLES(2), .CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .reset(reset_c), .start(start_c), .comp(comp_c),
    .sample(sample_c), .dac_code(dac_c), .result(result_c),
    .valid(valid_c), .busy(busy_c)
  );

  // Ideal comparator for the continuous instance.
  always_comb comp_c = (vin_c >= dac_c);

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Scoreboard pop on every valid strobe.
  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else check("result", result, q.pop_front());
    end
    if (valid_c) begin
      if (qc.size() == 0) check("c_unexpected_valid", 1, 0);
      else check("c_result", result_c, qc.pop_front());
      if (last_valid_c >= 0) check("c_valid_period", cyc - last_valid_c, 7);
      last_valid_c = cyc;
    end
  end

  // One conversion on u_dut; called at #1 after a rising edge.
  task automatic run_conv(input logic [4:0] vin, input bit use_pat,
                          input logic [4:0] pat, input bit noise, input int abort_at);
    logic [4:0] code, trial;
    logic [4:0] trials[5];
    logic       bits[5];
    code = 5'd0;
    for (int d = 0; d < 5; d++) begin
      trial     = code | (5'd1 << (4 - d));
      trials[d] = trial;
      bits[d]   = use_pat ? pat[4 - d] : (vin >= trial);
      if (bits[d]) code = trial;
    end
    start = 1'b1;
    q.push_back(code);
    @(posedge clk); #1;
    start = noise;
    check("sample_e1", sample, 1);
    check("busy_e1", busy, 1);
    check("dac_e1", dac_code, 0);
    @(posedge clk); #1;
    check("sample_e2", sample, 1);
    @(posedge clk); #1;
    check("sample_e3", sample, 0);
    check("busy_e3", busy, 1);
    for (int d = 0; d < 5; d++) begin
      check("dac_trial", dac_code, trials[d]);
      check("valid_low", valid, 0);
      check("result_held", result, last_result);
      comp = bits[d];
      if (d == abort_at) reset = 1'b1;
      @(posedge clk); #1;
      if (d == abort_at) begin
        check("abort_outs", {sample, valid, busy, dac_code, result}, 0);
        void'(q.pop_back());
        last_result = 5'd0;
        reset = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          check("abort_quiet", {sample, valid, busy}, 0);
        end
        return;
      end
    end
    start = 1'b0;
    check("valid_pulse", valid, 1);
    check("dac_final", dac_code, code);
    check("busy_done", busy, 0);
    last_result = code;
    @(posedge clk); #1;
    check("valid_one_cycle", valid, 0);
    check("result_hold", result, code);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; comp = 1'b0;
    reset_c = 1'b1; start_c = 1'b0; vin_c = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {sample, valid, busy, dac_code, result}, 0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check("idle_outs", {sample, valid, busy, dac_code, result}, 0);
    end

    run_conv(5'd19, 1'b0, 5'd0, 1'b0, -1);
    run_conv(5'd0,  1'b0, 5'd0, 1'b0, -1);
    run_conv(5'd31, 1'b0, 5'd0, 1'b0, -1);
    run_conv(5'd0,  1'b1, 5'b11000, 1'b0, -1);
    run_conv(5'd0,  1'b1, 5'b11111, 1'b0, -1);
    run_conv(5'd9,  1'b0, 5'd0, 1'b1, -1);
    run_conv(5'd13, 1'b0, 5'd0, 1'b0, 2);
    run_conv(5'd22, 1'b0, 5'd0, 1'b0, -1);

    @(posedge clk); #1;
    reset_c = 1'b0;
    qc.push_back(5'd5);
    qc.push_back(5'd27);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      check("c_busy", busy_c, 1);
      if (k == 8 || k == 15) check("c_valid_at", valid_c, 1);
      if (valid_c) vin_c = 5'd27;
    end
    reset_c = 1'b1;
    @(posedge clk); #1;
    check("queue_empty", q.size(), 0);
    check("c_queue_empty", qc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
